// File: rtl/merge.sv
// merge: N-to-1 round-robin bus merger; several masters share one slave,
// one transfer at a time, grant held until the slave returns ready.
// Revision: 1.0

`default_nettype none

`ifndef D
`define D 0
`endif
`ifndef I
`define I 1
`endif
`ifndef BUS_REQ_W
`define BUS_REQ_W(T, A) (((T) == `D) ? (1 + (A) + 32 + 4) : (1 + (A)))
`endif
`ifndef BUS_RESP_W
`define BUS_RESP_W 33
`endif

module merge #(
    parameter int TYPE      = `D,
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [N_MASTERS*`BUS_REQ_W(TYPE, ADDR_W)-1:0] m_req,
    output logic [N_MASTERS*`BUS_RESP_W-1:0]              m_resp,
    output logic [`BUS_REQ_W(TYPE, ADDR_W)-1:0]           s_req,
    input  logic [`BUS_RESP_W-1:0]                        s_resp
);

    localparam int c_REQ_W  = `BUS_REQ_W(TYPE, ADDR_W);
    localparam int c_RESP_W = `BUS_RESP_W;
    localparam int c_GW     = $clog2(N_MASTERS);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [0:0]             r_state;
    logic [c_GW-1:0]        r_grant;
    logic [c_GW-1:0]        r_prio;

    logic [N_MASTERS-1:0]   w_valid;
    logic [2*N_MASTERS-1:0] w_rot;
    logic [c_GW-1:0]        w_off;
    logic [c_GW:0]          w_sum;
    logic [c_GW-1:0]        w_winner;
    logic [c_GW-1:0]        w_grant_inc;
    logic                   w_any;
    logic                   w_ready;

    generate
        for (genvar g = 0; g < N_MASTERS; g++) begin : g_valid
            assign w_valid[g] = m_req[g*c_REQ_W + c_REQ_W - 1];
        end
    endgenerate

    assign w_any   = |w_valid;
    assign w_ready = s_resp[0];

    // Rotate the valid vector so bit 0 is the prio master; the lowest set bit
    // is the offset of the winner from prio.
    always_comb begin
        w_rot = {w_valid, w_valid} >> r_prio;
        w_off = '0;
        for (int j = N_MASTERS - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = c_GW'(j);
            end
        end
        w_sum    = {1'b0, r_prio} + {1'b0, w_off};
        w_winner = (w_sum >= (c_GW+1)'(N_MASTERS))
                 ? c_GW'(w_sum - (c_GW+1)'(N_MASTERS))
                 : c_GW'(w_sum);
    end

    assign w_grant_inc = (r_grant == c_GW'(N_MASTERS - 1)) ? '0 : r_grant + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_grant <= '0;
            r_prio  <= '0;
        end else if (r_state == c_IDLE) begin
            if (w_any) begin
                r_grant <= w_winner;
                r_state <= c_BUSY;
            end
        end else begin
            if (w_ready) begin
                r_state <= c_IDLE;
                r_prio  <= w_grant_inc;
            end
        end
    end

    // Request and response paths are pure muxes; nothing is forwarded in IDLE.
    always_comb begin
        s_req  = '0;
        m_resp = '0;
        if (r_state == c_BUSY) begin
            s_req                                  = m_req[r_grant*c_REQ_W +: c_REQ_W];
            m_resp[r_grant*c_RESP_W +: c_RESP_W]   = s_resp;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_merge.sv
// tb_merge: table-driven plus scoreboard bench for merge (N=4 data bus and
// N=2 instruction bus instances).
// Revision: 1.0

`default_nettype none

`ifndef D
`define D 0
`endif
`ifndef I
`define I 1
`endif

module tb_merge;

    logic clk;
    logic rst_n;

    logic [275:0] a_m_req;
    logic [131:0] a_m_resp;
    logic [68:0]  a_s_req;
    logic [32:0]  a_s_resp;
    logic [3:0]   a_mask;

    logic [33:0]  b_m_req;
    logic [65:0]  b_m_resp;
    logic [16:0]  b_s_req;
    logic [32:0]  b_s_resp;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [3:0]  mask;
        int          dly;
        logic [31:0] rdata;
        int          exp_g;
    } vec_t;

    typedef struct {
        int          g;
        logic [31:0] rdata;
    } sb_t;

    vec_t tbl[11];
    sb_t  sb[$];

    merge #(.TYPE(`D), .N_MASTERS(4), .ADDR_W(32)) u_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .m_req  (a_m_req),
        .m_resp (a_m_resp),
        .s_req  (a_s_req),
        .s_resp (a_s_resp)
    );

    merge #(.TYPE(`I), .N_MASTERS(2), .ADDR_W(16)) u_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .m_req  (b_m_req),
        .m_resp (b_m_resp),
        .s_req  (b_s_req),
        .s_resp (b_s_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [275:0] act, input logic [275:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Master m: addr = m<<4, wdata = {8{m}} ^ B4B4B4B4, wstrb = m ^ E
    function automatic logic [68:0] a_word(input int m, input logic v);
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        addr  = 32'(m) << 4;
        wdata = {8{4'(m)}} ^ 32'hB4B4B4B4;
        wstrb = 4'(m) ^ 4'hE;
        return {v, addr, wdata, wstrb};
    endfunction

    task automatic drive_a();
        for (int m = 0; m < 4; m++) a_m_req[m*69 +: 69] = a_word(m, a_mask[m]);
    endtask

    task automatic run_xfer(input logic [3:0] mask, input int dly, input logic [31:0] rdata,
                            input int exp_g, input logic [3:0] add_mask, input bit drop);
        logic [131:0] e_resp;
        sb_t          e;
        int           n_rdy;
        @(negedge clk);
        a_mask = mask;
        drive_a();
        a_s_resp = '0;
        #1;
        chk("idle_s_req", 276'(a_s_req), '0);
        chk("idle_m_resp", 276'(a_m_resp), '0);
        sb.push_back('{g: exp_g, rdata: rdata});
        @(posedge clk);
        for (int c = 0; c <= dly; c++) begin
            @(negedge clk);
            if (c == 1) a_mask = a_mask | add_mask;
            if (c == 2 && drop) a_mask[exp_g] = 1'b0;
            drive_a();
            a_s_resp = {rdata, (c == dly)};
            #1;
            e = sb[0];
            chk("busy_s_req", 276'(a_s_req), 276'(a_word(e.g, a_mask[e.g])));
            e_resp = '0;
            e_resp[e.g*33 +: 33] = a_s_resp;
            chk("busy_m_resp", 276'(a_m_resp), 276'(e_resp));
            if (c == dly) begin
                n_rdy = 0;
                for (int m = 0; m < 4; m++) n_rdy += int'(a_m_resp[m*33]);
                chk("ready_count", 276'(n_rdy), 276'(1));
                chk("ready_rdata", 276'(a_m_resp[e.g*33+1 +: 32]), 276'(e.rdata));
                void'(sb.pop_front());
            end
            @(posedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        for (int i = 0; i < 5; i++) tbl[i] = '{4'b1111, 1, 32'h1000_0000 + 32'(i), i % 4};
        tbl[5]  = '{4'b0010, 3, 32'h0BAD_0001, 1};
        tbl[6]  = '{4'b0001, 2, 32'h0BAD_0002, 0};
        tbl[7]  = '{4'b1001, 1, 32'h0BAD_0003, 3};
        tbl[8]  = '{4'b0110, 0, 32'h0BAD_0004, 1};
        tbl[9]  = '{4'b1100, 2, 32'h0BAD_0005, 2};
        tbl[10] = '{4'b0011, 0, 32'h0BAD_0006, 0};

        rst_n    = 1'b0;
        a_mask   = 4'b1111;
        drive_a();
        a_s_resp = {32'hFFFF_FFFF, 1'b1};
        b_m_req  = '0;
        b_s_resp = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_s_req", 276'(a_s_req), '0);
        chk("reset_m_resp", 276'(a_m_resp), '0);
        chk("reset_b_s_req", 276'(b_s_req), '0);
        a_mask = '0;
        drive_a();
        a_s_resp = '0;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) run_xfer(tbl[i].mask, tbl[i].dly, tbl[i].rdata, tbl[i].exp_g, 4'b0000, 1'b0);

        // Slave ready while IDLE with nobody requesting must be ignored
        @(negedge clk);
        a_mask = '0;
        drive_a();
        a_s_resp = {32'hDEAD_BEEF, 1'b1};
        #1;
        chk("idle_rdy_s_req", 276'(a_s_req), '0);
        chk("idle_rdy_m_resp", 276'(a_m_resp), '0);
        @(negedge clk);
        #1;
        chk("idle_rdy2_m_resp", 276'(a_m_resp), '0);

        // Master 0 holds grant through a late joiner and its own valid drop
        run_xfer(4'b0001, 5, 32'h5555_0000, 0, 4'b0010, 1'b1);
        run_xfer(4'b0010, 1, 32'h5555_0001, 1, 4'b0000, 1'b0);

        // Reset while master 2 is mid-transfer
        @(negedge clk);
        a_mask = 4'b0100;
        drive_a();
        a_s_resp = '0;
        @(posedge clk);
        @(negedge clk);
        a_s_resp = {32'hCAFE_F00D, 1'b0};
        #1;
        chk("pre_rst_s_req", 276'(a_s_req), 276'(a_word(2, 1'b1)));
        chk("pre_rst_m_resp", 276'(a_m_resp[2*33 +: 33]), 276'({32'hCAFE_F00D, 1'b0}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_s_req", 276'(a_s_req), '0);
        chk("async_rst_m_resp", 276'(a_m_resp), '0);
        a_mask = '0;
        drive_a();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_xfer(4'b1111, 1, 32'h7777_0000, 0, 4'b0000, 1'b0);

        // Instruction-bus instance
        @(negedge clk);
        b_m_req = {1'b1, 16'h0010, 1'b1, 16'h0000};
        #1;
        chk("b_idle_s_req", 276'(b_s_req), '0);
        @(posedge clk);
        @(negedge clk);
        b_s_resp = {32'h1234_5678, 1'b1};
        #1;
        chk("b_s_req", 276'(b_s_req), 276'({1'b1, 16'h0000}));
        chk("b_m_resp", 276'(b_m_resp), 276'({33'h0, 32'h1234_5678, 1'b1}));
        @(posedge clk);
        @(negedge clk);
        b_m_req  = '0;
        b_s_resp = '0;
        #1;
        chk("b_after_m_resp", 276'(b_m_resp), '0);

        chk("sb_empty", 276'(sb.size()), '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
